seven_seg_scan_ctrl: RTL

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

---
 rtl/seven_seg_scan_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed driver for a 4-digit seven-segment display.
// Loads are double-buffered and applied only at frame boundaries to avoid tearing.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        blank_zeros,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  numeral_bit,
    output logic [3:0]  digit_en_n,
    output logic        digit_blank,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [15:0]     display_q, display_d;
    logic [15:0]     pending_q, pending_d;
    logic            full_q, full_d;

    logic [3:0]      numeral_d;
    logic [3:0]      digit_en_n_d;
    logic            digit_blank_d;
    logic            frame_done_d;
    logic            accept;
    logic            boundary;
    logic [3:1]      zero_from;
    logic [3:0]      nibble;
    logic            blanked;

    // Handshake: a transfer happens on a rising edge where load_valid and
    // load_ready are both high; load_ready is the registered inverse of full.
    assign accept   = load_valid && load_ready;
    assign boundary = frame_done;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            IDLE: begin
                idx_d  = 2'd0;
                cnt_d  = '0;
                gcnt_d = '0;
                if (enable) state_d = SCAN;
            end
            SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    gcnt_d  = '0;
                    state_d = GUARD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GUARD: begin
                if (gcnt_q == GUARD_LAST) begin
                    gcnt_d  = '0;
                    idx_d   = idx_q + 2'd1;
                    state_d = SCAN;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
                gcnt_d  = '0;
            end
        endcase
        if (!enable) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            gcnt_d  = '0;
        end
    end

    // Pending and display never change together except at the boundary swap.
    always_comb begin
        display_d = display_q;
        pending_d = pending_q;
        full_d    = full_q;
        if (boundary && full_q) begin
            display_d = pending_q;
            full_d    = 1'b0;
        end
        if (accept) begin
            pending_d = load_data;
            full_d    = 1'b1;
        end
    end

    // Outputs are computed from next state so the registered copies line up
    // with the state they describe.
    always_comb begin
        zero_from[3] = (display_d[15:12] == 4'h0);
        zero_from[2] = zero_from[3] && (display_d[11:8] == 4'h0);
        zero_from[1] = zero_from[2] && (display_d[7:4] == 4'h0);
        case (idx_d)
            2'd0:    nibble = display_d[3:0];
            2'd1:    nibble = display_d[7:4];
            2'd2:    nibble = display_d[11:8];
            default: nibble = display_d[15:12];
        endcase
        blanked = 1'b0;
        if (blank_zeros && (idx_d != 2'd0)) blanked = zero_from[idx_d];

        numeral_d     = 4'h0;
        digit_en_n_d  = 4'hF;
        digit_blank_d = 1'b1;
        if ((state_d == SCAN) && !blanked) begin
            numeral_d     = nibble;
            digit_en_n_d  = ~(4'b0001 << idx_d);
            digit_blank_d = 1'b0;
        end
        frame_done_d = (state_d == GUARD) && (idx_d == 2'd3) && (gcnt_d == GUARD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            gcnt_q      <= '0;
            display_q   <= 16'h0000;
            pending_q   <= 16'h0000;
            full_q      <= 1'b0;
            load_ready  <= 1'b1;
            numeral_bit <= 4'h0;
            digit_en_n  <= 4'hF;
            digit_blank <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            gcnt_q      <= gcnt_d;
            display_q   <= display_d;
            pending_q   <= pending_d;
            full_q      <= full_d;
            load_ready  <= ~full_d;
            numeral_bit <= numeral_d;
            digit_en_n  <= digit_en_n_d;
            digit_blank <= digit_blank_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule
